// File: rtl/cabac_pkg.sv
// Shared definitions for the CABAC offset-register refill block:
// command encodings, controller states and the bits-needed reset value.
package cabac_pkg;

    localparam logic [1:0] OP_INIT  = 2'd0;
    localparam logic [1:0] OP_SHIFT = 2'd1;
    localparam logic [1:0] OP_SUB   = 2'd2;
    localparam logic [1:0] OP_FLUSH = 2'd3;

    typedef enum logic [1:0] {
        ST_UNINIT    = 2'd0,
        ST_INIT_FILL = 2'd1,
        ST_IDLE      = 2'd2,
        ST_WAIT_BYTE = 2'd3
    } state_e;

    localparam logic signed [3:0] BITS_NEEDED_INIT = -4'sd8;

endpackage

// File: rtl/cabac_byte_fifo.sv
// Small byte FIFO for bitstream refill; extra pointer bit separates full
// from empty, and a pop only ever sees bytes that were stored earlier.
module cabac_byte_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [7:0] push_data,
    input  logic       push,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic [7:0]     mem [FIFO_DEPTH];
    logic           do_push;
    logic           do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/cabac_value_refill.sv
// Arithmetic-decoder offset register with byte refill: executes INIT, SHIFT,
// SUB and FLUSH commands and stalls the command handshake while starved.
module cabac_value_refill
    import cabac_pkg::*;
#(
    parameter int VALUE_W    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          in_byte,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [3:0]          cmd_shift,
    input  logic [VALUE_W-1:0]  cmd_operand,
    output logic [VALUE_W-1:0]  value,
    output logic signed [3:0]   bits_needed,
    output logic                initialized,
    output logic                err
);

    localparam int INIT_BYTES = VALUE_W / 8;

    state_e              state, state_nxt;
    logic [VALUE_W-1:0]  value_q, value_nxt;
    logic signed [3:0]   bn_q, bn_nxt;
    logic                init_q, init_nxt;
    logic                err_q, err_nxt;
    logic [2:0]          fill_cnt, fill_cnt_nxt;
    logic [VALUE_W-1:0]  s_lat, s_lat_nxt;
    logic [2:0]          b_lat, b_lat_nxt;

    logic                fifo_full, fifo_empty, fifo_pop, fifo_clr;
    logic [7:0]          fifo_data;
    logic                accept;
    logic                shift_ok;
    logic [VALUE_W-1:0]  shifted;
    logic signed [4:0]   b_sum;

    // Merge a refill byte into the shifted offset at bit position b.
    function automatic logic [VALUE_W-1:0] add_byte(
        input logic [VALUE_W-1:0] s,
        input logic [7:0]         byt,
        input logic [2:0]         b
    );
        return s + ({{(VALUE_W-8){1'b0}}, byt} << b);
    endfunction

    cabac_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (fifo_clr),
        .push_data (in_byte),
        .push      (in_valid),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign in_ready    = !fifo_full;
    assign cmd_ready   = (state == ST_UNINIT) || (state == ST_IDLE);
    assign accept      = cmd_valid && cmd_ready;
    assign value       = value_q;
    assign bits_needed = bn_q;
    assign initialized = init_q;
    assign err         = err_q;

    assign shift_ok = (cmd_shift != 4'd0) && (cmd_shift <= 4'd8);
    assign shifted  = value_q << cmd_shift;
    assign b_sum    = $signed({bn_q[3], bn_q}) + $signed({1'b0, cmd_shift});

    always_comb begin
        state_nxt    = state;
        value_nxt    = value_q;
        bn_nxt       = bn_q;
        init_nxt     = init_q;
        err_nxt      = err_q;
        fill_cnt_nxt = fill_cnt;
        s_lat_nxt    = s_lat;
        b_lat_nxt    = b_lat;
        fifo_pop     = 1'b0;
        fifo_clr     = 1'b0;

        unique case (state)
            ST_UNINIT: begin
                if (accept) begin
                    if (cmd_op == OP_INIT) begin
                        value_nxt    = '0;
                        fill_cnt_nxt = '0;
                        state_nxt    = ST_INIT_FILL;
                    end else if (cmd_op == OP_SHIFT || cmd_op == OP_SUB) begin
                        err_nxt = 1'b1;
                    end
                end
            end

            ST_INIT_FILL: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    value_nxt = {value_q[VALUE_W-9:0], fifo_data};
                    if (fill_cnt == 3'(INIT_BYTES - 1)) begin
                        bn_nxt       = BITS_NEEDED_INIT;
                        init_nxt     = 1'b1;
                        fill_cnt_nxt = '0;
                        state_nxt    = ST_IDLE;
                    end else begin
                        fill_cnt_nxt = fill_cnt + 3'd1;
                    end
                end
            end

            ST_IDLE: begin
                if (accept) begin
                    unique case (cmd_op)
                        OP_SUB: begin
                            value_nxt = value_q - cmd_operand;
                            if (cmd_operand > value_q) err_nxt = 1'b1;
                        end
                        OP_SHIFT: begin
                            if (!shift_ok) begin
                                err_nxt = 1'b1;
                            end else if (b_sum[4]) begin
                                value_nxt = shifted;
                                bn_nxt    = b_sum[3:0];
                            end else if (!fifo_empty) begin
                                fifo_pop  = 1'b1;
                                value_nxt = add_byte(shifted, fifo_data, b_sum[2:0]);
                                bn_nxt    = {1'b1, b_sum[2:0]};
                            end else begin
                                s_lat_nxt = shifted;
                                b_lat_nxt = b_sum[2:0];
                                state_nxt = ST_WAIT_BYTE;
                            end
                        end
                        OP_INIT: begin
                            value_nxt    = '0;
                            init_nxt     = 1'b0;
                            fill_cnt_nxt = '0;
                            state_nxt    = ST_INIT_FILL;
                        end
                        default: begin
                            fifo_clr  = 1'b1;
                            init_nxt  = 1'b0;
                            bn_nxt    = BITS_NEEDED_INIT;
                            state_nxt = ST_UNINIT;
                        end
                    endcase
                end
            end

            ST_WAIT_BYTE: begin
                // value keeps its pre-command contents until the byte lands.
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    value_nxt = add_byte(s_lat, fifo_data, b_lat);
                    bn_nxt    = {1'b1, b_lat};
                    state_nxt = ST_IDLE;
                end
            end

            default: state_nxt = ST_UNINIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_UNINIT;
            value_q  <= '0;
            bn_q     <= BITS_NEEDED_INIT;
            init_q   <= 1'b0;
            err_q    <= 1'b0;
            fill_cnt <= '0;
        end else begin
            state    <= state_nxt;
            value_q  <= value_nxt;
            bn_q     <= bn_nxt;
            init_q   <= init_nxt;
            err_q    <= err_nxt;
            fill_cnt <= fill_cnt_nxt;
        end
    end

    // Latched partial shift result for a starved SHIFT; data only.
    always_ff @(posedge clk) begin
        s_lat <= s_lat_nxt;
        b_lat <= b_lat_nxt;
    end

endmodule

// File: tb/tb_cabac_value_refill.sv
// Directed bench for cabac_value_refill with hand-computed expectations.
module tb_cabac_value_refill;
    import cabac_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [3:0]        cmd_shift;
    logic [15:0]       cmd_operand;
    logic [15:0]       value;
    logic signed [3:0] bits_needed;
    logic              initialized;
    logic              err;

    int checks = 0;
    int errors = 0;

    cabac_value_refill #(.VALUE_W(16), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_shift   (cmd_shift),
        .cmd_operand (cmd_operand),
        .value       (value),
        .bits_needed (bits_needed),
        .initialized (initialized),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_byte  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [3:0] sh,
                            input logic [15:0] opd, input string tag);
        bit done = 0;
        cmd_op = op; cmd_shift = sh; cmd_operand = opd; cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (cmd_ready) done = 1;
            tick();
        end
        cmd_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_accept: command not accepted within 20 cycles", tag);
        end
    endtask

    task automatic wait_ready(input string tag);
        bit done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (cmd_ready) done = 1;
            else tick();
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_wait: cmd_ready stayed low for 20 cycles", tag);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic do_init(input logic [7:0] b0, input logic [7:0] b1, input string tag);
        push_byte(b0);
        push_byte(b1);
        send_cmd(OP_INIT, 4'd0, 16'h0, tag);
        wait_ready(tag);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (value !== 16'h0000) begin errors++; $display("FAIL reset_value: got %h want 0000", value); end
        checks++; if (bits_needed !== 4'b1000) begin errors++; $display("FAIL reset_bn: got %0d want -8", bits_needed); end
        checks++; if (initialized !== 1'b0) begin errors++; $display("FAIL reset_init: got %b want 0", initialized); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (in_ready !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: in_ready %b cmd_ready %b want 1 1", in_ready, cmd_ready); end
    endtask

    task automatic test_init();
        push_byte(8'hA5);
        push_byte(8'h3C);
        send_cmd(OP_INIT, 4'd0, 16'h0, "init");
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL init_busy: cmd_ready %b want 0", cmd_ready); end
        wait_ready("init");
        checks++; if (value !== 16'hA53C) begin errors++; $display("FAIL init_value: got %h want a53c", value); end
        checks++; if (bits_needed !== 4'b1000) begin errors++; $display("FAIL init_bn: got %0d want -8", bits_needed); end
        checks++; if (initialized !== 1'b1) begin errors++; $display("FAIL init_flag: got %b want 1", initialized); end
    endtask

    task automatic test_shift();
        send_cmd(OP_SHIFT, 4'd3, 16'h0, "shift3");
        checks++; if (value !== 16'h29E0) begin errors++; $display("FAIL shift3_value: got %h want 29e0", value); end
        checks++; if (bits_needed !== 4'b1011) begin errors++; $display("FAIL shift3_bn: got %0d want -5", bits_needed); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL shift3_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_refill();
        push_byte(8'h81);
        send_cmd(OP_SHIFT, 4'd6, 16'h0, "refill");
        checks++; if (value !== 16'h7902) begin errors++; $display("FAIL refill_value: got %h want 7902", value); end
        checks++; if (bits_needed !== 4'b1001) begin errors++; $display("FAIL refill_bn: got %0d want -7", bits_needed); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL refill_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_starve();
        do_init(8'hA5, 8'h3C, "starve_init");
        send_cmd(OP_SHIFT, 4'd3, 16'h0, "starve_s3");
        send_cmd(OP_SHIFT, 4'd6, 16'h0, "starve_s6");
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL starve_stall: cmd_ready %b want 0", cmd_ready); end
        tick(); tick(); tick();
        checks++; if (value !== 16'h29E0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL starve_frozen: value %h ready %b want 29e0 0", value, cmd_ready); end
        push_byte(8'h81);
        checks++; if (value !== 16'h29E0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL starve_no_bypass: value %h ready %b want 29e0 0", value, cmd_ready); end
        tick();
        checks++; if (value !== 16'h7902) begin errors++; $display("FAIL starve_value: got %h want 7902", value); end
        checks++; if (bits_needed !== 4'b1001 || cmd_ready !== 1'b1) begin errors++; $display("FAIL starve_done: bn %0d ready %b want -7 1", bits_needed, cmd_ready); end
    endtask

    task automatic test_sub();
        send_cmd(OP_SUB, 4'd0, 16'h1902, "sub1");
        checks++; if (value !== 16'h6000 || err !== 1'b0) begin errors++; $display("FAIL sub_value: value %h err %b want 6000 0", value, err); end
        send_cmd(OP_SUB, 4'd0, 16'h7000, "sub2");
        checks++; if (value !== 16'hF000) begin errors++; $display("FAIL sub_wrap: got %h want f000", value); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL sub_err: got %b want 1", err); end
    endtask

    task automatic test_protocol();
        do_reset();
        send_cmd(OP_SHIFT, 4'd2, 16'h0, "uninit_shift");
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL uninit_err: got %b want 1", err); end
        checks++; if (cmd_ready !== 1'b1 || initialized !== 1'b0 || value !== 16'h0) begin errors++; $display("FAIL uninit_state: ready %b init %b value %h want 1 0 0000", cmd_ready, initialized, value); end
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fifo_full: in_ready %b want 0", in_ready); end
        send_cmd(OP_INIT, 4'd0, 16'h0, "full_init");
        wait_ready("full_init");
        checks++; if (value !== 16'h1122 || in_ready !== 1'b1) begin errors++; $display("FAIL full_init_value: value %h in_ready %b want 1122 1", value, in_ready); end
        send_cmd(OP_FLUSH, 4'd0, 16'h0, "flush");
        checks++; if (initialized !== 1'b0 || bits_needed !== 4'b1000 || cmd_ready !== 1'b1) begin errors++; $display("FAIL flush_state: init %b bn %0d ready %b want 0 -8 1", initialized, bits_needed, cmd_ready); end
        do_init(8'h55, 8'h66, "post_flush");
        checks++; if (value !== 16'h5566) begin errors++; $display("FAIL flush_empty: value %h want 5566", value); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_init(8'h12, 8'h34, "mid_init");
        send_cmd(OP_SHIFT, 4'd8, 16'h0, "mid_shift");
        checks++; if (cmd_ready !== 1'b0 || value !== 16'h1234) begin errors++; $display("FAIL mid_wait: ready %b value %h want 0 1234", cmd_ready, value); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (value !== 16'h0 || bits_needed !== 4'b1000 || initialized !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mid_reset_out: value %h bn %0d init %b err %b want 0000 -8 0 0", value, bits_needed, initialized, err); end
        checks++; if (cmd_ready !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: cmd %b in %b want 1 1", cmd_ready, in_ready); end
        do_init(8'hBE, 8'hEF, "bad_init");
        send_cmd(OP_SHIFT, 4'd0, 16'h0, "bad_shift");
        checks++; if (err !== 1'b1 || value !== 16'hBEEF || bits_needed !== 4'b1000) begin errors++; $display("FAIL bad_shift: err %b value %h bn %0d want 1 beef -8", err, value, bits_needed); end
    endtask

    initial begin
        rst = 1'b1; in_byte = '0; in_valid = 1'b0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_shift = '0; cmd_operand = '0;
        test_reset();
        test_init();
        test_shift();
        test_refill();
        test_starve();
        test_sub();
        test_protocol();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
